// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage register with a one-entry
// skid buffer and a synchronous flush that turns the stage into a bubble.
// Carries PC, data payload and control bundle. An all-zero control bundle is a
// bubble, so the control output is zero whenever no entry is presented.
// Optional feature: define PIPE_STAGE_PERF_EN to add the stall_cnt and
// bubble_cnt performance counters.
module pipe_stage_reg #(
    parameter int              PC_W     = 32,
    parameter int              DATA_W   = 96,
    parameter int              CTRL_W   = 12,
    parameter logic [PC_W-1:0] PC_RESET = PC_W'(32'h0040_0000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    // Main register drives the outputs; the skid register catches the one
    // entry that can arrive while main is stalled.
    logic              main_valid_reg, main_valid_next;
    logic [PC_W-1:0]   main_pc_reg,    main_pc_next;
    logic [DATA_W-1:0] main_data_reg,  main_data_next;
    logic [CTRL_W-1:0] main_ctrl_reg,  main_ctrl_next;
    logic              skid_valid_reg, skid_valid_next;
    logic [PC_W-1:0]   skid_pc_reg,    skid_pc_next;
    logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg,  skid_ctrl_next;

    logic accept;
    logic release_fire;

    // Ready depends only on the skid valid bit, so there is no combinational
    // path from out_ready back to in_ready.
    assign in_ready     = !skid_valid_reg;
    assign accept       = in_valid && in_ready;
    assign release_fire = main_valid_reg && out_ready;

    assign out_valid = main_valid_reg;
    assign out_pc    = main_pc_reg;
    assign out_data  = main_data_reg;
    assign out_ctrl  = main_valid_reg ? main_ctrl_reg : '0;
    assign occupancy = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};

    // Next-state selection: flush first, then skid drain, then main/skid load.
    always_comb begin
        main_valid_next = main_valid_reg;
        main_pc_next    = main_pc_reg;
        main_data_next  = main_data_reg;
        main_ctrl_next  = main_ctrl_reg;
        skid_valid_next = skid_valid_reg;
        skid_pc_next    = skid_pc_reg;
        skid_data_next  = skid_data_reg;
        skid_ctrl_next  = skid_ctrl_reg;

        if (flush) begin
            // Drop everything held and whatever is offered this cycle.
            main_valid_next = 1'b0;
            main_pc_next    = PC_RESET;
            main_ctrl_next  = '0;
            skid_valid_next = 1'b0;
            skid_ctrl_next  = '0;
        end else if (skid_valid_reg) begin
            // in_ready is low here, so only a drain of skid into main can occur.
            if (release_fire) begin
                main_valid_next = 1'b1;
                main_pc_next    = skid_pc_reg;
                main_data_next  = skid_data_reg;
                main_ctrl_next  = skid_ctrl_reg;
                skid_valid_next = 1'b0;
                skid_ctrl_next  = '0;
            end
        end else if (!main_valid_reg || release_fire) begin
            if (accept) begin
                main_valid_next = 1'b1;
                main_pc_next    = in_pc;
                main_data_next  = in_data;
                main_ctrl_next  = in_ctrl;
            end else if (release_fire) begin
                // Becomes a bubble; PC and data keep their last values.
                main_valid_next = 1'b0;
                main_ctrl_next  = '0;
            end
        end else if (accept) begin
            // Main is stalled: park the new entry behind it.
            skid_valid_next = 1'b1;
            skid_pc_next    = in_pc;
            skid_data_next  = in_data;
            skid_ctrl_next  = in_ctrl;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_reg <= 1'b0;
            main_pc_reg    <= PC_RESET;
            main_data_reg  <= '0;
            main_ctrl_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_pc_reg    <= '0;
            skid_data_reg  <= '0;
            skid_ctrl_reg  <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_pc_reg    <= main_pc_next;
            main_data_reg  <= main_data_next;
            main_ctrl_reg  <= main_ctrl_next;
            skid_valid_reg <= skid_valid_next;
            skid_pc_reg    <= skid_pc_next;
            skid_data_reg  <= skid_data_next;
            skid_ctrl_reg  <= skid_ctrl_next;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] bubble_cnt_reg;

    assign stall_cnt  = stall_cnt_reg;
    assign bubble_cnt = bubble_cnt_reg;

    // Stall and bubble cycle counters; cleared by reset only, wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (main_valid_reg && !out_ready) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (!main_valid_reg) begin
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed scenarios plus randomized traffic,
// all checked against a queue-based model of a two-deep FIFO stage.
module tb_pipe_stage_reg;

    localparam int              PC_W     = 32;
    localparam int              DATA_W   = 96;
    localparam int              CTRL_W   = 12;
    localparam logic [PC_W-1:0] PC_RESET = 32'h0040_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif

    pipe_stage_reg #(
        .PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .PC_RESET(PC_RESET)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the stage is a FIFO of depth two; the front entry is
    // what the outputs show, and the last shown PC/data persist when empty.
    entry_t            q[$];
    logic [PC_W-1:0]   shown_pc;
    logic [DATA_W-1:0] shown_data;
    logic [31:0]       m_stall;
    logic [31:0]       m_bubble;
    logic [PC_W-1:0]   seen[$];

    function automatic entry_t rand_entry(input logic [PC_W-1:0] pc);
        entry_t e;
        e.pc   = pc;
        e.data = {$urandom, $urandom, $urandom};
        e.ctrl = CTRL_W'($urandom_range(1, 4095));
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        shown_pc   = PC_RESET;
        shown_data = '0;
        m_stall    = 0;
        m_bubble   = 0;
    endtask

    // Drive one cycle of inputs, advance the model, then step past the edge.
    task automatic drive_cycle(input logic v, input logic r, input logic f, input entry_t e);
        logic acc, rel;
        in_valid  = v;
        out_ready = r;
        flush     = f;
        in_pc     = e.pc;
        in_data   = e.data;
        in_ctrl   = e.ctrl;
        if (out_valid && out_ready && !f) seen.push_back(out_pc);
        acc = v && (q.size() < 2);
        rel = (q.size() > 0) && r;
        if (q.size() == 0) m_bubble = m_bubble + 1;
        else if (!r)       m_stall  = m_stall + 1;
        if (f) begin
            q.delete();
            shown_pc = PC_RESET;
        end else begin
            if (rel) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (q.size() > 0) begin
                shown_pc   = q[0].pc;
                shown_data = q[0].data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 0; out_ready = 0; flush = 0;
        in_pc = '0; in_data = '0; in_ctrl = '0;
        reset = 1'b1;
        #12;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        entry_t a, b;
        apply_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_pc !== PC_RESET || out_data !== '0 ||
            occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ctrl=%h pc=%h occ=%0d rdy=%b, required 0/000/%h/0/1",
                     out_valid, out_ctrl, out_pc, occupancy, in_ready, PC_RESET);
        end
        a = rand_entry(32'h1000);
        b = rand_entry(32'h1004);
        drive_cycle(1, 0, 0, a);
        drive_cycle(1, 0, 0, b);
        n_cmp++;
        if (occupancy !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_fill: occupancy=%0d required 2", occupancy);
        end
        // Mid-cycle reset: outputs must clear without waiting for a clock edge.
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_pc !== PC_RESET ||
            occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b ctrl=%h pc=%h occ=%0d rdy=%b, required 0/000/%h/0/1",
                     out_valid, out_ctrl, out_pc, occupancy, in_ready, PC_RESET);
        end
        in_valid = 0;
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_streaming();
        entry_t e;
        for (int i = 0; i < 8; i++) begin
            e = rand_entry(PC_RESET + 32'(4 * i));
            drive_cycle(1, 1, 0, e);
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== e.pc || out_data !== e.data || out_ctrl !== e.ctrl ||
                in_ready !== 1'b1 || occupancy !== 2'd1) begin
                n_fail++;
                $display("FAIL stream[%0d]: valid=%b pc=%h ctrl=%h rdy=%b occ=%0d, required 1/%h/%h/1/1",
                         i, out_valid, out_pc, out_ctrl, in_ready, occupancy, e.pc, e.ctrl);
            end
        end
        drive_cycle(0, 1, 0, e);
        $display("test_streaming done");
    endtask

    task automatic test_back_pressure();
        entry_t a, b, c, idle;
        logic [PC_W-1:0]   hold_pc;
        logic [DATA_W-1:0] hold_data;
        logic [CTRL_W-1:0] hold_ctrl;
        int guard;
        a = rand_entry(32'hA000); b = rand_entry(32'hB000); c = rand_entry(32'hC000);
        idle = '0;
        seen.delete();
        drive_cycle(1, 0, 0, a);
        hold_pc = out_pc; hold_data = out_data; hold_ctrl = out_ctrl;
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== a.pc || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_cycle1: valid=%b pc=%h rdy=%b, required 1/%h/1", out_valid, out_pc, in_ready, a.pc);
        end
        drive_cycle(1, 0, 0, b);
        drive_cycle(1, 0, 0, c);
        n_cmp++;
        if (out_pc !== hold_pc || out_data !== hold_data || out_ctrl !== hold_ctrl ||
            in_ready !== 1'b0 || occupancy !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_hold: pc=%h ctrl=%h rdy=%b occ=%0d, required %h/%h/0/2",
                     out_pc, out_ctrl, in_ready, occupancy, hold_pc, hold_ctrl);
        end
        // Release; upstream keeps offering C until it is taken.
        guard = 0;
        while (q.size() != 0 || in_valid) begin
            if (q.size() < 2 && in_valid && in_pc == c.pc) begin
                drive_cycle(1, 1, 0, c);
                in_valid = 0;
            end else if (in_valid) drive_cycle(1, 1, 0, c);
            else drive_cycle(0, 1, 0, idle);
            guard++;
            if (guard > 20) break;
        end
        drive_cycle(0, 1, 0, idle);
        n_cmp++;
        if (seen.size() != 3 || seen[0] !== a.pc || seen[1] !== b.pc || seen[2] !== c.pc) begin
            n_fail++;
            $display("FAIL bp_order: released %0d entries (first %h), required %h,%h,%h",
                     seen.size(), (seen.size() > 0) ? seen[0] : '0, a.pc, b.pc, c.pc);
        end
        $display("test_back_pressure done");
    endtask

    task automatic test_flush();
        entry_t a, b, d, idle;
        a = rand_entry(32'h2000); b = rand_entry(32'h2004); d = rand_entry(32'hDDDD);
        idle = '0;
        seen.delete();
        drive_cycle(1, 0, 0, a);
        drive_cycle(1, 0, 0, b);
        drive_cycle(1, 0, 1, d);
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_pc !== PC_RESET ||
            occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_state: valid=%b ctrl=%h pc=%h occ=%0d rdy=%b, required 0/000/%h/0/1",
                     out_valid, out_ctrl, out_pc, occupancy, in_ready, PC_RESET);
        end
        for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, idle);
        n_cmp++;
        if (seen.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: %0d entries released after flush, valid=%b, required 0/0",
                     seen.size(), out_valid);
        end
        $display("test_flush done");
    endtask

    task automatic test_bubble();
        entry_t e, idle;
        e = rand_entry(32'h3000);
        e.ctrl = 12'hFFF;
        idle = '0;
        drive_cycle(1, 0, 0, e);
        n_cmp++;
        if (out_valid !== 1'b1 || out_ctrl !== 12'hFFF) begin
            n_fail++;
            $display("FAIL bubble_load: valid=%b ctrl=%h, required 1/fff", out_valid, out_ctrl);
        end
        drive_cycle(0, 1, 0, idle);
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 12'h000 || out_pc !== e.pc || out_data !== e.data) begin
            n_fail++;
            $display("FAIL bubble_after_release: valid=%b ctrl=%h pc=%h, required 0/000/%h",
                     out_valid, out_ctrl, out_pc, e.pc);
        end
        $display("test_bubble done");
    endtask

    task automatic test_random();
        entry_t e;
        logic v, r, f;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            f = ($urandom_range(0, 39) == 0);
            e = rand_entry($urandom);
            drive_cycle(v, r, f, e);
            n_cmp++;
            if (out_valid !== (q.size() > 0) || out_pc !== shown_pc || out_data !== shown_data ||
                out_ctrl !== ((q.size() > 0) ? q[0].ctrl : '0) ||
                occupancy !== 2'(q.size()) || in_ready !== (q.size() < 2)) begin
                n_fail++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random[%0d]: valid=%b pc=%h ctrl=%h occ=%0d rdy=%b, required %b/%h/%h/%0d/%b",
                             i, out_valid, out_pc, out_ctrl, occupancy, in_ready,
                             (q.size() > 0), shown_pc, (q.size() > 0) ? q[0].ctrl : '0,
                             q.size(), (q.size() < 2));
            end
        end
        $display("test_random done");
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        entry_t e, idle;
        idle = '0;
        apply_reset();
        e = rand_entry(32'h4000);
        drive_cycle(1, 0, 0, e);
        for (int i = 0; i < 5; i++) drive_cycle(0, 0, 0, idle);
        drive_cycle(0, 1, 0, idle);
        for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, idle);
        n_cmp++;
        if (stall_cnt !== m_stall || bubble_cnt !== m_bubble) begin
            n_fail++;
            $display("FAIL perf_count: stall=%0d bubble=%0d, required %0d/%0d",
                     stall_cnt, bubble_cnt, m_stall, m_bubble);
        end
        drive_cycle(1, 0, 0, e);
        drive_cycle(0, 0, 1, idle);
        n_cmp++;
        if (stall_cnt !== m_stall || bubble_cnt !== m_bubble) begin
            n_fail++;
            $display("FAIL perf_flush: stall=%0d bubble=%0d, required %0d/%0d",
                     stall_cnt, bubble_cnt, m_stall, m_bubble);
        end
        drive_cycle(1, 0, 0, e);
        force dut.stall_cnt_reg = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_reg;
        m_stall = 32'hFFFF_FFFF;
        drive_cycle(0, 0, 0, idle);
        n_cmp++;
        if (stall_cnt !== 32'd0 || stall_cnt !== m_stall) begin
            n_fail++;
            $display("FAIL perf_wrap: stall=%h required 00000000", stall_cnt);
        end
        $display("test_perf done");
    endtask
`endif

    initial begin
        reset = 1'b0;
        model_reset();
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_bubble();
        test_random();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
